// File: rtl/apb_pkg.sv
// Shared types for the APB requester bridge: FSM encoding and response codes.
// Latency: none (declarations only).
// Backpressure: n/a.
package apb_pkg;

    // One-hot FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_SETUP  = 3'b010,
        ST_ACCESS = 3'b100
    } apb_state_t;

    localparam int PROT_W = 3;

    localparam logic [1:0] APB_OK      = 2'b00;
    localparam logic [1:0] APB_SLVERR  = 2'b01;
    localparam logic [1:0] APB_DECERR  = 2'b10;
    localparam logic [1:0] APB_TIMEOUT = 2'b11;

endpackage

// File: rtl/apb_addr_decode.sv
// Address-to-slave decoder: one-hot select, slave index and decode error.
// Latency: purely combinational.
// Backpressure: none.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int NUM_SLAVES    = 4,
    parameter int SLV_ADDR_BITS = 12,
    parameter int IDX_W         = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic [IDX_W-1:0]      idx,
    output logic                  decerr
);

    // Bits above the slave index must be zero for a valid region
    localparam int HI_LSB = SLV_ADDR_BITS + IDX_W;

    // Extract index, flag out-of-map addresses, build the one-hot select
    always_comb begin
        idx    = addr[SLV_ADDR_BITS +: IDX_W];
        decerr = ((addr >> HI_LSB) != '0) || (32'(idx) >= NUM_SLAVES);
        sel    = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (!decerr && (idx == IDX_W'(k))) begin
                sel[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_nslv.sv
// Command-to-APB4 requester bridge for NUM_SLAVES peripherals with timeout.
// Latency: accept at N, SETUP N+1, ACCESS N+2.., response N+3 with no waits.
// Backpressure: cmd_ready_o only in IDLE; rsp_valid_o is a pulse, no stall.
module apb_master_nslv
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SLV_ADDR_BITS  = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             pclk_i,
    input  logic                             prst_i,
    input  logic                             cmd_valid_i,
    output logic                             cmd_ready_o,
    input  logic                             cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]            cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]          cmd_strb_i,
    input  logic [PROT_W-1:0]                cmd_prot_i,
    output logic                             rsp_valid_o,
    output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
    output logic [1:0]                       rsp_status_o,
    output logic [ADDR_WIDTH-1:0]            paddr_o,
    output logic [PROT_W-1:0]                pprot_o,
    output logic [NUM_SLAVES-1:0]            psel_o,
    output logic                             penable_o,
    output logic                             pwrite_o,
    output logic [DATA_WIDTH-1:0]            pwdata_o,
    output logic [DATA_WIDTH/8-1:0]          pstrb_o,
    input  logic [NUM_SLAVES-1:0]            pready_i,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata_i,
    input  logic [NUM_SLAVES-1:0]            pslverr_i
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    apb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [NUM_SLAVES-1:0]   dec_sel;
    logic [IDX_W-1:0]        dec_idx;
    logic                    dec_err;

    logic                    cmd_ready_d, rsp_valid_d, penable_d, pwrite_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_d, pwdata_d;
    logic [1:0]              rsp_status_d;
    logic [ADDR_WIDTH-1:0]   paddr_d;
    logic [PROT_W-1:0]       pprot_d;
    logic [NUM_SLAVES-1:0]   psel_d;
    logic [STRB_W-1:0]       pstrb_d;

    logic                    sel_ready, sel_err, timeout_hit;
    logic [DATA_WIDTH-1:0]   sel_rdata;

    apb_addr_decode #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .NUM_SLAVES    (NUM_SLAVES),
        .SLV_ADDR_BITS (SLV_ADDR_BITS),
        .IDX_W         (IDX_W)
    ) u_decode (
        .addr   (cmd_addr_i),
        .sel    (dec_sel),
        .idx    (dec_idx),
        .decerr (dec_err)
    );

    // Observe only the slave latched at accept time
    always_comb begin
        sel_ready   = pready_i[idx_q];
        sel_err     = pslverr_i[idx_q];
        sel_rdata   = prdata_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
        timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Next-state and next-output logic; APB fields hold unless changed here
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        paddr_d      = paddr_o;
        pprot_d      = pprot_o;
        psel_d       = psel_o;
        penable_d    = penable_o;
        pwrite_d     = pwrite_o;
        pwdata_d     = pwdata_o;
        pstrb_d      = pstrb_o;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = '0;
        rsp_status_d = APB_OK;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    if (dec_err) begin
                        // Unmapped address: answer directly, never touch the bus
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = APB_DECERR;
                    end else begin
                        paddr_d   = cmd_addr_i;
                        pprot_d   = cmd_prot_i;
                        pwrite_d  = cmd_write_i;
                        pwdata_d  = cmd_wdata_i;
                        pstrb_d   = cmd_write_i ? cmd_strb_i : '0;
                        psel_d    = dec_sel;
                        penable_d = 1'b0;
                        idx_d     = dec_idx;
                        cnt_d     = '0;
                        state_d   = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (sel_ready || timeout_hit) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    pstrb_d     = '0;
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    if (sel_ready) begin
                        rsp_status_d = sel_err ? APB_SLVERR : APB_OK;
                        rsp_rdata_d  = (!pwrite_o && !sel_err) ? sel_rdata : '0;
                    end else begin
                        rsp_status_d = APB_TIMEOUT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // FSM state, latched slave index and wait counter
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs; reset drops any in-flight transfer silently
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            cmd_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_rdata_o  <= '0;
            rsp_status_o <= '0;
            paddr_o      <= '0;
            pprot_o      <= '0;
            psel_o       <= '0;
            penable_o    <= 1'b0;
            pwrite_o     <= 1'b0;
            pwdata_o     <= '0;
            pstrb_o      <= '0;
        end else begin
            cmd_ready_o  <= cmd_ready_d;
            rsp_valid_o  <= rsp_valid_d;
            rsp_rdata_o  <= rsp_rdata_d;
            rsp_status_o <= rsp_status_d;
            paddr_o      <= paddr_d;
            pprot_o      <= pprot_d;
            psel_o       <= psel_d;
            penable_o    <= penable_d;
            pwrite_o     <= pwrite_d;
            pwdata_o     <= pwdata_d;
            pstrb_o      <= pstrb_d;
        end
    end

endmodule

// File: tb/tb_apb_master_nslv.sv
// Bench for apb_master_nslv: directed scenarios plus random commands.
// Latency: checks every cycle of every transfer against a timing model.
// Backpressure: waits (bounded) for cmd_ready_o before each command.
module tb_apb_master_nslv;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NS  = 4;
    localparam int SAB = 12;
    localparam int TMO = 8;
    localparam int SW  = DW / 8;

    logic              pclk_i = 1'b0;
    logic              prst_i = 1'b0;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic              cmd_write_i = 1'b0;
    logic [AW-1:0]     cmd_addr_i = '0;
    logic [DW-1:0]     cmd_wdata_i = '0;
    logic [SW-1:0]     cmd_strb_i = '0;
    logic [2:0]        cmd_prot_i = '0;
    logic              rsp_valid_o;
    logic [DW-1:0]     rsp_rdata_o;
    logic [1:0]        rsp_status_o;
    logic [AW-1:0]     paddr_o;
    logic [2:0]        pprot_o;
    logic [NS-1:0]     psel_o;
    logic              penable_o;
    logic              pwrite_o;
    logic [DW-1:0]     pwdata_o;
    logic [SW-1:0]     pstrb_o;
    logic [NS-1:0]     pready_i = '0;
    logic [NS*DW-1:0]  prdata_i = '0;
    logic [NS-1:0]     pslverr_i = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    apb_master_nslv #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .NUM_SLAVES     (NS),
        .SLV_ADDR_BITS  (SAB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .pclk_i       (pclk_i),
        .prst_i       (prst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_write_i  (cmd_write_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .cmd_strb_i   (cmd_strb_i),
        .cmd_prot_i   (cmd_prot_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_status_o (rsp_status_o),
        .paddr_o      (paddr_o),
        .pprot_o      (pprot_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .pwrite_o     (pwrite_o),
        .pwdata_o     (pwdata_o),
        .pstrb_o      (pstrb_o),
        .pready_i     (pready_i),
        .prdata_i     (prdata_i),
        .pslverr_i    (pslverr_i)
    );

    always #5 pclk_i = ~pclk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Selected slave gets the given behaviour; every other slave gets noise
    task automatic drive_slaves(input int k, input logic rdy, input logic err,
                                input logic [DW-1:0] d);
        for (int j = 0; j < NS; j++) begin
            if (j == k) begin
                pready_i[j]             = rdy;
                pslverr_i[j]            = err;
                prdata_i[j*DW +: DW]    = d;
            end else begin
                pready_i[j]             = 1'($urandom);
                pslverr_i[j]            = 1'($urandom);
                prdata_i[j*DW +: DW]    = $urandom;
            end
        end
    endtask

    // One command, checked every cycle. waits = ACCESS cycles with pready low
    // before the ready cycle. Called at a negedge; returns at the negedge of
    // the response cycle so back-to-back commands run at full rate.
    task automatic run_cmd(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                           input logic [2:0] prot, input int waits,
                           input logic err, input logic [DW-1:0] sdata);
        int            region, k, lat;
        logic          dec;
        logic [1:0]    st;
        logic [DW-1:0] rd;
        logic [NS-1:0] onehot;
        region = int'(addr / 4096);
        dec    = (region >= NS);
        k      = dec ? -1 : region;
        onehot = '0;
        if (!dec) onehot[region] = 1'b1;
        if (dec) begin
            lat = 1; st = 2'b10;
        end else if (waits >= TMO) begin
            lat = 2 + TMO; st = 2'b11;
        end else begin
            lat = 3 + waits; st = err ? 2'b01 : 2'b00;
        end
        rd = (!dec && !wr && waits < TMO && !err) ? sdata : '0;

        for (int i = 0; i < 20 && cmd_ready_o !== 1'b1; i++) @(negedge pclk_i);
        chk("cmd_ready_idle", cmd_ready_o, 1'b1);
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        cmd_strb_i  = strb;
        cmd_prot_i  = prot;
        drive_slaves(k, 1'b0, err, sdata);
        @(negedge pclk_i);
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'($urandom);
        cmd_addr_i  = $urandom;
        cmd_wdata_i = $urandom;
        cmd_strb_i  = SW'($urandom);
        cmd_prot_i  = 3'($urandom);
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) @(negedge pclk_i);
            chk("rsp_valid", rsp_valid_o, (c == lat));
            chk("psel", psel_o, (c < lat) ? onehot : '0);
            chk("penable", penable_o, (!dec && c >= 2 && c < lat));
            if (!dec && c < lat) begin
                chk("paddr", paddr_o, addr);
                chk("pwrite", pwrite_o, wr);
                chk("pwdata", pwdata_o, wdata);
                chk("pprot", pprot_o, prot);
                chk("pstrb", pstrb_o, wr ? strb : '0);
                chk("cmd_ready_busy", cmd_ready_o, 1'b0);
            end
            if (c == lat) begin
                chk("rsp_status", rsp_status_o, st);
                chk("rsp_rdata", rsp_rdata_o, rd);
                chk("pstrb_done", pstrb_o, '0);
                chk("cmd_ready_rsp", cmd_ready_o, 1'b1);
                if (!dec) begin
                    chk("paddr_kept", paddr_o, addr);
                    chk("pwdata_kept", pwdata_o, wdata);
                    chk("pprot_kept", pprot_o, prot);
                end
            end
            drive_slaves(k, (c >= 2 + waits), err, sdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        // Reset: outputs all zero while asserted
        #1 prst_i = 1'b1;
        repeat (2) @(negedge pclk_i);
        chk("rst_cmd_ready", cmd_ready_o, 1'b0);
        chk("rst_rsp_valid", rsp_valid_o, 1'b0);
        chk("rst_psel", psel_o, '0);
        chk("rst_penable", penable_o, 1'b0);
        chk("rst_paddr", paddr_o, '0);
        chk("rst_pstrb", pstrb_o, '0);
        prst_i = 1'b0;

        // Directed scenarios
        run_cmd(1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 4'hF, 3'd2, 0, 1'b0, 32'h0);
        run_cmd(1'b0, 32'h0000_3004, 32'h0,         4'h0, 3'd1, 5, 1'b0, 32'h1234_5678);
        run_cmd(1'b1, 32'h0000_2000, 32'hA5A5_5A5A, 4'h3, 3'd0, 1, 1'b1, 32'hFFFF_FFFF);
        run_cmd(1'b0, 32'h0000_2008, 32'h1111_2222, 4'hF, 3'd5, 0, 1'b0, 32'hCAFE_F00D);
        run_cmd(1'b0, 32'h0000_100C, 32'h0,         4'hF, 3'd3, 2, 1'b1, 32'h7777_7777);
        run_cmd(1'b1, 32'h0001_0000, 32'h0BAD_0BAD, 4'hF, 3'd0, 0, 1'b0, 32'h0);
        run_cmd(1'b0, 32'h0000_4000, 32'h0,         4'h0, 3'd0, 0, 1'b0, 32'h0);
        run_cmd(1'b0, 32'h0000_0FF0, 32'h0,         4'h0, 3'd7, 30, 1'b0, 32'h5555_AAAA);
        run_cmd(1'b1, 32'h0000_0000, 32'h0102_0304, 4'h9, 3'd4, 0, 1'b0, 32'h0);
        run_cmd(1'b0, 32'h0000_1000, 32'h0,         4'h0, 3'd0, TMO - 1, 1'b0, 32'h600D_600D);

        // Reset in the middle of an ACCESS phase
        for (int i = 0; i < 20 && cmd_ready_o !== 1'b1; i++) @(negedge pclk_i);
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b1;
        cmd_addr_i  = 32'h0000_1000;
        cmd_wdata_i = 32'h1357_9BDF;
        cmd_strb_i  = 4'hF;
        drive_slaves(1, 1'b0, 1'b0, 32'h0);
        @(negedge pclk_i);
        cmd_valid_i = 1'b0;
        drive_slaves(1, 1'b0, 1'b0, 32'h0);
        @(negedge pclk_i);
        chk("pre_rst_psel", psel_o, 4'b0010);
        chk("pre_rst_penable", penable_o, 1'b1);
        #2 prst_i = 1'b1;
        #1;
        chk("async_rst_psel", psel_o, '0);
        chk("async_rst_penable", penable_o, 1'b0);
        chk("async_rst_rsp", rsp_valid_o, 1'b0);
        drive_slaves(1, 1'b1, 1'b0, 32'h0);
        repeat (2) begin
            @(negedge pclk_i);
            chk("in_rst_rsp", rsp_valid_o, 1'b0);
            chk("in_rst_psel", psel_o, '0);
        end
        prst_i = 1'b0;
        @(negedge pclk_i);
        chk("post_rst_rsp", rsp_valid_o, 1'b0);
        run_cmd(1'b0, 32'h0000_3FFC, 32'h0, 4'hF, 3'd6, 1, 1'b0, 32'h8765_4321);

        // Random commands, including unmapped regions and timeouts
        for (int n = 0; n < 40; n++) begin
            a = AW'($urandom_range(0, 5) * 4096 + $urandom_range(0, 4095));
            if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(14, 31));
            run_cmd(1'($urandom), a, $urandom, SW'($urandom), 3'($urandom),
                    int'($urandom_range(0, 10)), 1'($urandom), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
